instr_check_seq: RTL and testbench

INSTR_CHECK_SEQ -- requirements
Module: instr_check_seq

---
 rtl/instr_check_pkg.sv | 21 ++
 rtl/instr_check_vec_mem.sv | 47 ++++
 rtl/instr_check_seq.sv | 170 +++++++++++++++++
 tb/tb_instr_check_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_check_pkg.sv
// Shared types and constants for the instruction-check sequencer:
// FSM states, the NOP word, and the layout of a vector's fields.
package instr_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Field offsets past the instruction slots: INSTRS_PER_TEST+0 is the
  // expected value, INSTRS_PER_TEST+1 is the check register.
  localparam int FIELD_EXP_OFS = 0;
  localparam int FIELD_REG_OFS = 1;

endpackage

// File: rtl/instr_check_vec_mem.sv
// Test-vector storage: per test, INSTRS_PER_TEST instruction words, an expected
// value and a check register. One write port, one combinational read port.
module instr_check_vec_mem
  import instr_check_pkg::*;
#(
  parameter int MAX_TESTS       = 16,
  parameter int INSTRS_PER_TEST = 2,
  parameter int IDX_W           = 4,
  parameter int FLD_W           = 2,
  parameter int SLOT_W          = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [FLD_W-1:0]  wr_field,
  input  logic [31:0]       wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [SLOT_W-1:0] rd_slot,
  output logic [31:0]       rd_instr,
  output logic [31:0]       rd_exp,
  output logic [4:0]        rd_creg
);

  localparam logic [FLD_W-1:0] FIELD_EXP = FLD_W'(INSTRS_PER_TEST + FIELD_EXP_OFS);
  localparam logic [FLD_W-1:0] FIELD_REG = FLD_W'(INSTRS_PER_TEST + FIELD_REG_OFS);

  logic [31:0] instr_mem [MAX_TESTS][INSTRS_PER_TEST];
  logic [31:0] exp_mem   [MAX_TESTS];
  logic [4:0]  creg_mem  [MAX_TESTS];

  // Storage is never reset; field codes beyond the check register are dropped.
  always_ff @(posedge clk) begin
    if (we && (int'(wr_idx) < MAX_TESTS)) begin
      if (int'(wr_field) < INSTRS_PER_TEST)
        instr_mem[wr_idx][wr_field[SLOT_W-1:0]] <= wr_data;
      else if (wr_field == FIELD_EXP)
        exp_mem[wr_idx] <= wr_data;
      else if (wr_field == FIELD_REG)
        creg_mem[wr_idx] <= wr_data[4:0];
    end
  end

  assign rd_instr = instr_mem[rd_idx][rd_slot];
  assign rd_exp   = exp_mem[rd_idx];
  assign rd_creg  = creg_mem[rd_idx];

endmodule

// File: rtl/instr_check_seq.sv
// Instruction-check sequencer: feeds stored instructions to a core, lets it
// settle, then compares a core register against the stored expected value.
module instr_check_seq
  import instr_check_pkg::*;
#(
  parameter int MAX_TESTS       = 16,
  parameter int INSTRS_PER_TEST = 2,
  parameter int SETTLE_CYCLES   = 1,
  localparam int CNT_W  = $clog2(MAX_TESTS + 1),
  localparam int IDX_W  = (MAX_TESTS > 1) ? $clog2(MAX_TESTS) : 1,
  localparam int FLD_W  = $clog2(INSTRS_PER_TEST + 2),
  localparam int SLOT_W = (INSTRS_PER_TEST > 1) ? $clog2(INSTRS_PER_TEST) : 1,
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tests,
  input  logic             ld_we,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [FLD_W-1:0] ld_field,
  input  logic [31:0]      ld_data,
  output logic [31:0]      imem_out,
  output logic [4:0]       ra3,
  input  logic [31:0]      rd3,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [IDX_W-1:0] first_fail,
  output logic             any_fail
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  test_q, test_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
  logic [IDX_W-1:0]  ff_q, ff_d;
  logic              any_q, any_d;

  logic [31:0] cur_instr, cur_exp;
  logic [4:0]  cur_creg;
  logic        last_slot, last_test;
  logic [CNT_W-1:0] clamped;

  instr_check_vec_mem #(
    .MAX_TESTS      (MAX_TESTS),
    .INSTRS_PER_TEST(INSTRS_PER_TEST),
    .IDX_W          (IDX_W),
    .FLD_W          (FLD_W),
    .SLOT_W         (SLOT_W)
  ) u_mem (
    .clk     (clk),
    .we      (ld_we && !busy),
    .wr_idx  (ld_idx),
    .wr_field(ld_field),
    .wr_data (ld_data),
    .rd_idx  (test_q),
    .rd_slot (slot_q),
    .rd_instr(cur_instr),
    .rd_exp  (cur_exp),
    .rd_creg (cur_creg)
  );

  assign clamped   = (num_tests > CNT_W'(MAX_TESTS)) ? CNT_W'(MAX_TESTS) : num_tests;
  assign last_slot = (slot_q == SLOT_W'(INSTRS_PER_TEST - 1));
  assign last_test = ((CNT_W'(test_q) + CNT_W'(1)) == total_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      test_q   <= '0;
      slot_q   <= '0;
      settle_q <= '0;
      total_q  <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      ff_q     <= '0;
      any_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      test_q   <= test_d;
      slot_q   <= slot_d;
      settle_q <= settle_d;
      total_q  <= total_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ff_q     <= ff_d;
      any_q    <= any_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    test_d   = test_q;
    slot_d   = slot_q;
    settle_d = settle_q;
    total_d  = total_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ff_d     = ff_q;
    any_d    = any_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          total_d  = clamped;
          pass_d   = '0;
          fail_d   = '0;
          ff_d     = '0;
          any_d    = 1'b0;
          test_d   = '0;
          slot_d   = '0;
          settle_d = '0;
          state_d  = (clamped == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (last_slot) begin
          slot_d   = '0;
          settle_d = '0;
          state_d  = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = CHECK;
        else settle_d = settle_q + 1'b1;
      end
      CHECK: begin
        // Exact 4-state match: an X/Z from the core counts as a failure.
        if (rd3 === cur_exp) begin
          pass_d = pass_q + 1'b1;
        end else begin
          fail_d = fail_q + 1'b1;
          if (!any_q) begin
            any_d = 1'b1;
            ff_d  = test_q;
          end
        end
        if (last_test) begin
          state_d = DONE;
        end else begin
          test_d  = test_q + 1'b1;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The check register is presented from the last issue slot so the core's
  // debug read path has settled by the CHECK cycle.
  always_comb begin
    imem_out = (state_q == ISSUE) ? cur_instr : NOP;
    ra3      = 5'd0;
    if ((state_q == ISSUE && last_slot) || state_q == SETTLE || state_q == CHECK)
      ra3 = cur_creg;
  end

  assign busy       = (state_q == ISSUE) || (state_q == SETTLE) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign first_fail = ff_q;
  assign any_fail   = any_q;

endmodule

// File: tb/tb_instr_check_seq.sv
// Directed bench for instr_check_seq: a scoreboard queue holds the expected
// imem_out/ra3 per busy cycle, and a reference model predicts the counters.
module tb_instr_check_seq;
  import instr_check_pkg::*;

  localparam int MT  = 16;
  localparam int IPT = 2;
  localparam int SC  = 1;

  logic        clk = 1'b0;
  logic        rst, start, ld_we;
  logic [4:0]  num_tests;
  logic [3:0]  ld_idx;
  logic [1:0]  ld_field;
  logic [31:0] ld_data, imem_out, rd3;
  logic [4:0]  ra3;
  logic        busy, done, any_fail;
  logic [4:0]  pass_cnt, fail_cnt;
  logic [3:0]  first_fail;

  logic [31:0] core_regs [32];
  assign rd3 = core_regs[ra3];

  typedef struct packed {
    logic [31:0] imem;
    logic [4:0]  ra;
  } sb_t;
  sb_t sb_q[$];

  logic [31:0] m_instr [MT][IPT];
  logic [31:0] m_exp [MT];
  logic [4:0]  m_reg [MT];

  int checks = 0;
  int failures = 0;
  int e_pass, e_fail, e_ff;
  logic e_any;

  instr_check_seq #(.MAX_TESTS(MT), .INSTRS_PER_TEST(IPT), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tests(num_tests),
    .ld_we(ld_we), .ld_idx(ld_idx), .ld_field(ld_field), .ld_data(ld_data),
    .imem_out(imem_out), .ra3(ra3), .rd3(rd3),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail(first_fail), .any_fail(any_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: one expected entry per busy cycle.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_busy", 32'(busy), 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("imem_out", imem_out, e.imem);
        chk("ra3", 32'(ra3), 32'(e.ra));
      end
    end
  end

  task automatic load(input int idx, input int fld, input logic [31:0] d);
    ld_we = 1'b1; ld_idx = 4'(idx); ld_field = 2'(fld); ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
    if (fld < IPT) m_instr[idx][fld] = d;
    else if (fld == IPT) m_exp[idx] = d;
    else m_reg[idx] = d[4:0];
  endtask

  task automatic load_vec(input int t, input logic [31:0] i0, input logic [31:0] i1,
                          input logic [31:0] e, input logic [4:0] r);
    load(t, 0, i0);
    load(t, 1, i1);
    load(t, 2, e);
    load(t, 3, 32'(r));
  endtask

  // Push expectations for n requested tests and pulse start (with any
  // same-cycle load the caller has already placed on the ld_* pins).
  task automatic run_start(input int n);
    int eff;
    eff = (n > MT) ? MT : n;
    e_pass = 0; e_fail = 0; e_ff = 0; e_any = 1'b0;
    for (int t = 0; t < eff; t++) begin
      for (int s = 0; s < IPT; s++)
        sb_q.push_back({m_instr[t][s], (s == IPT - 1) ? m_reg[t] : 5'd0});
      for (int k = 0; k < SC; k++) sb_q.push_back({NOP, m_reg[t]});
      sb_q.push_back({NOP, m_reg[t]});
      if (core_regs[m_reg[t]] === m_exp[t]) e_pass++;
      else begin
        if (!e_any) e_ff = t;
        e_any = 1'b1;
        e_fail++;
      end
    end
    num_tests = 5'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ld_we = 1'b0;
  endtask

  task automatic run_finish(input string tag);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pass"}, 32'(pass_cnt), 32'(e_pass));
    chk({tag, "_fail"}, 32'(fail_cnt), 32'(e_fail));
    chk({tag, "_first_fail"}, 32'(first_fail), 32'(e_ff));
    chk({tag, "_any_fail"}, 32'(any_fail), 32'(e_any));
    chk({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_imem"}, imem_out, NOP);
    chk({tag, "_ra3"}, 32'(ra3), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass_cnt), 32'd0);
    chk({tag, "_fail"}, 32'(fail_cnt), 32'd0);
    chk({tag, "_first_fail"}, 32'(first_fail), 32'd0);
    chk({tag, "_any_fail"}, 32'(any_fail), 32'd0);
  endtask

  function automatic logic [31:0] enc_addi(input int rd, input int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'd0, 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] enc_slti(input int rd, input int rs, input int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'(rs), 3'b010, 5'(rd), 7'h13};
  endfunction

  int sa [7] = '{1, 5, 3, -2, 7, 0, -5};
  int sb [7] = '{5, 1, 3, 1, -3, 1, -4};

  initial begin
    rst = 1'b1; start = 1'b0; ld_we = 1'b0; num_tests = '0;
    ld_idx = '0; ld_field = '0; ld_data = '0;
    for (int r = 0; r < 32; r++) core_regs[r] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    // Zero tests: straight to DONE, never busy.
    @(posedge clk); #1;
    run_start(0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_pass", 32'(pass_cnt), 32'd0);
    chk("zero_fail", 32'(fail_cnt), 32'd0);
    @(posedge clk); #1;

    // Single vector; check-register load shares the cycle with start.
    load(0, 0, 32'h00f00093);
    load(0, 1, 32'h0100a193);
    load(0, 2, 32'd1);
    core_regs[3] = 32'd1;
    ld_we = 1'b1; ld_idx = 4'd0; ld_field = 2'd3; ld_data = 32'd3;
    m_reg[0] = 5'd3;
    run_start(1);
    run_finish("single");
    chk("single_pass_const", 32'(pass_cnt), 32'd1);

    // Seven SLTI vectors, the third one with a wrong expected value.
    for (int t = 0; t < 7; t++) begin
      logic [31:0] res;
      res = (sa[t] < sb[t]) ? 32'd1 : 32'd0;
      core_regs[10 + t] = res;
      load_vec(t, enc_addi(1, sa[t]), enc_slti(10 + t, 1, sb[t]),
               (t == 2) ? 32'd1 : res, 5'(10 + t));
    end
    run_start(7);
    run_finish("slti");
    chk("slti_ff_const", 32'(first_fail), 32'd2);

    // Full storage, request 20 to exercise the clamp.
    for (int t = 0; t < MT; t++) begin
      logic [31:0] v;
      v = 32'(t * 3 + 5);
      core_regs[t + 1] = v;
      load_vec(t, 32'h1000_0013 + 32'(t << 7), 32'h2000_0013 ^ 32'(t << 15),
               (t % 5 == 4) ? v + 32'd1 : v, 5'(t + 1));
    end
    run_start(20);
    run_finish("clamp");
    chk("clamp_total", 32'(pass_cnt) + 32'(fail_cnt), 32'd16);

    // Reset during SETTLE of test 1, then rerun from intact storage.
    run_start(3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("abort");
    sb_q.delete();
    @(posedge clk); #1;
    run_start(3);
    run_finish("rerun");

    // start and loads while busy must be ignored.
    run_start(3);
    repeat (2) @(negedge clk);
    ld_we = 1'b1; ld_idx = 4'd1; ld_field = 2'd0; ld_data = 32'hdead_beef;
    start = 1'b1; num_tests = 5'd1;
    @(posedge clk); #1;
    ld_we = 1'b0; start = 1'b0;
    run_finish("busy_poke");
    @(posedge clk); #1;
    run_start(3);
    run_finish("after_poke");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
